// File: rtl/asr_access_if.sv
// ASR access bus: request/response handshake plus the register-file side port.
// The master side is the pipeline/register-file environment; the unit is the slave.
interface asr_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [4:0]  req_addr;
    logic [31:0] req_rs1;
    logic [31:0] req_op2;
    logic        req_super;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_trap;
    logic [1:0]  rsp_trap_type;
    logic        asr_wr;
    logic [4:0]  asr_sel;
    logic [31:0] asr_in;
    logic [31:0] asr_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_rs1, req_op2, req_super, flush,
        output rsp_ready, asr_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_trap, rsp_trap_type,
        input  asr_wr, asr_sel, asr_in
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_rs1, req_op2, req_super, flush,
        input  rsp_ready, asr_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_trap, rsp_trap_type,
        output asr_wr, asr_sel, asr_in
    );
endinterface

// File: rtl/asr_access_unit.sv
// RDASR/WRASR access sequencer: privilege check, delayed register-file write,
// read capture and a held response, with flush and async reset cancellation.
module asr_access_unit #(
    parameter int unsigned WR_DELAY = 3
) (
    input  logic        clk,
    input  logic        rst,
    asr_access_if.slave bus
);
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam bit          NO_DELAY = (WR_DELAY == 0);
    localparam logic [CNT_W-1:0] CNT_INIT = NO_DELAY ? '0 : CNT_W'(WR_DELAY - 1);

    typedef enum logic [2:0] {IDLE, READ, WDLY, WCOMMIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          tt_q;

    logic                accept_c;
    logic [1:0]          tt_c;
    logic                ready_c;
    logic                rsp_valid_c;
    logic [DATA_W-1:0]   rsp_data_c;
    logic                rsp_trap_c;
    logic [1:0]          rsp_tt_c;
    logic                asr_wr_c;
    logic [ADDR_W-1:0]   asr_sel_c;
    logic [DATA_W-1:0]   asr_in_c;

    // Trap classification of the request currently offered on the bus
    always_comb begin
        tt_c = 2'b00;
        if (bus.req_addr == ADDR_W'(0)) begin
            tt_c = 2'b01;
        end else if (bus.req_addr[ADDR_W-1] && !bus.req_super) begin
            tt_c = 2'b10;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept_c    = 1'b0;
        ready_c     = 1'b0;
        rsp_valid_c = 1'b0;
        rsp_data_c  = '0;
        rsp_trap_c  = 1'b0;
        rsp_tt_c    = 2'b00;
        asr_wr_c    = 1'b0;
        asr_sel_c   = '0;
        asr_in_c    = '0;
        case (state_q)
            IDLE: begin
                ready_c  = 1'b1;
                accept_c = bus.req_valid & ~bus.flush;
                if (accept_c) begin
                    if (tt_c != 2'b00) begin
                        state_d = RESP;
                    end else if (!bus.req_wr) begin
                        state_d = READ;
                    end else if (NO_DELAY) begin
                        state_d = WCOMMIT;
                    end else begin
                        state_d = WDLY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            READ: begin
                asr_sel_c = addr_q;
                state_d   = bus.flush ? IDLE : RESP;
            end
            WDLY: begin
                asr_sel_c = addr_q;
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = WCOMMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WCOMMIT: begin
                // A flush arriving here is too late: the write is committed
                asr_wr_c  = 1'b1;
                asr_sel_c = addr_q;
                asr_in_c  = wdata_q;
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                rsp_data_c  = rdata_q;
                rsp_trap_c  = (tt_q != 2'b00);
                rsp_tt_c    = tt_q;
                if (bus.flush || bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request payload capture and read-data sampling at the end of READ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            tt_q    <= 2'b00;
        end else if (accept_c) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_rs1 ^ bus.req_op2;
            rdata_q <= '0;
            tt_q    <= tt_c;
        end else if (state_q == READ) begin
            rdata_q <= bus.asr_rdata;
        end
    end

    // Ready is held low for the whole reset assertion
    assign bus.req_ready     = ready_c & ~rst;
    assign bus.rsp_valid     = rsp_valid_c;
    assign bus.rsp_data      = rsp_data_c;
    assign bus.rsp_trap      = rsp_trap_c;
    assign bus.rsp_trap_type = rsp_tt_c;
    assign bus.asr_wr        = asr_wr_c;
    assign bus.asr_sel       = asr_sel_c;
    assign bus.asr_in        = asr_in_c;
endmodule
